// File: rtl/clk_div_sel_ctrl.sv
// Rate generator and tap scheduler for the clock-generation area.
// A free-running counter stands in for a ripple divider chain; tap k of the
// counter toggles at CLK/2^(k+1).
// One tap at a time drives a 50% divided output and a one-cycle strobe.
// A rate change is requested with a REQ/BUSY/ACK handshake. It is applied
// only on an edge where both the old and the new tap wrap to zero, so the
// divided output never produces a runt pulse.
module clk_div_sel_ctrl #(
    parameter int N_TAPS    = 22,
    parameter int SEL_W     = 5,
    parameter int RESET_SEL = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sel_req_i,
    input  logic [SEL_W-1:0] sel_in_i,
    output logic             sel_busy_o,
    output logic             sel_ack_o,
    output logic             sel_err_o,
    output logic [SEL_W-1:0] sel_cur_o,
    output logic             div_out_o,
    output logic             div_stb_o
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [SEL_W:0]  NTapsCmp = (SEL_W+1)'(N_TAPS);
    localparam logic [SEL_W-1:0] ResetSel = SEL_W'(RESET_SEL);
    localparam logic [N_TAPS-1:0] CntOne = N_TAPS'(1);

    state_t              state_q, state_d;
    logic [N_TAPS-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_cur_q, sel_cur_d;
    logic [SEL_W-1:0]    sel_new_q, sel_new_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic [SEL_W-1:0]    selMax;
    logic [N_TAPS-1:0]   curMask;
    logic [N_TAPS-1:0]   maxMask;
    logic                curBoundary;
    logic                maxBoundary;
    logic                selValid;

    // Low-bit masks for the active tap and for the slower of the active and
    // pending taps; all ones under a mask marks the last cycle of a period.
    always_comb begin
        selMax = (sel_cur_q > sel_new_q) ? sel_cur_q : sel_new_q;
        curMask = '0;
        maxMask = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            curMask[i] = (i <= int'(sel_cur_q));
            maxMask[i] = (i <= int'(selMax));
        end
        curBoundary = ((cnt_q & curMask) == curMask);
        maxBoundary = ((cnt_q & maxMask) == maxMask);
        selValid    = ({1'b0, sel_in_i} < NTapsCmp);
    end

    // Counter advance plus the handshake FSM that picks when the tap swaps.
    always_comb begin
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        sel_new_d = sel_new_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        cnt_d     = en_i ? (cnt_q + CntOne) : '0;

        case (state_q)
            IDLE: begin
                if (sel_req_i) begin
                    if (selValid) begin
                        sel_new_d = sel_in_i;
                        busy_d    = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                // With the counter stopped every tap is already low, so the
                // swap is safe on the very next edge.
                if (!en_i || maxBoundary) begin
                    sel_cur_d = sel_new_q;
                    ack_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that also drops any
    // pending request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_cur_q <= ResetSel;
            sel_new_q <= ResetSel;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_cur_q <= sel_cur_d;
            sel_new_q <= sel_new_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign sel_busy_o = busy_q;
    assign sel_ack_o  = ack_q;
    assign sel_err_o  = err_q;
    assign sel_cur_o  = sel_cur_q;
    assign div_out_o  = cnt_q[sel_cur_q];
    assign div_stb_o  = en_i & curBoundary;

endmodule
